gray_cycle_monitor: RTL and testbench
=====================================

Name: gray_cycle_monitor

Overview:
- Downstream consumer of the 2-bit T-flip-flop state machine whose state {A,B} advances 00->10->11->01->00 while x=0 and holds while x=1.
- Samples the 2-bit state each Clk and checks every transition against that legal Gray sequence.
- Produces step and home pulses, a revolution counter, a hold-duration counter with a stall flag, and a sticky illegal-transition fault with first-error capture.
- Same clock and reset domain as the producing machine; no synchronizer required.

Parameters:
- CNT_W, 8, width of cycle_cnt (completed revolutions).
- HOLD_W, 8, width of hold_cnt (consecutive hold cycles).
- HOLD_LIMIT, 16, hold_cnt value at or above which stall asserts; must be less than 2^HOLD_W.

Ports:
- Clk  input  1  clock, all state updates on posedge.
- rst  input  1  asynchronous active-low reset.
- state_in  input  2  {A,B} from the upstream machine.
- clr_err  input  1  synchronous request to leave FAULT.
- clr_cnt  input  1  synchronous clear of cycle_cnt and cycle_ovf.
- step  output  1  one-cycle pulse per legal advance.
- home  output  1  one-cycle pulse on legal 01->00 advance.
- cycle_cnt  output  CNT_W  completed revolutions, wraps.
- cycle_ovf  output  1  sticky; set when cycle_cnt wraps.
- hold_cnt  output  HOLD_W  consecutive cycles without change, saturating.
- stall  output  1  hold_cnt >= HOLD_LIMIT.
- err  output  1  high while in FAULT.
- err_from  output  2  prev state at first illegal transition.
- err_to  output  2  state_in at first illegal transition.

Behaviour:
- Reset (rst=0, async): prev=00, FSM=RUN; all outputs 0.
- prev=00 matches the upstream reset state, so the first sample after reset is checked normally.
- Each posedge, classify (prev, state_in):
  - HOLD: state_in==prev.
  - ADV: legal successor (00->10, 10->11, 11->01, 01->00).
  - ILL: anything else, i.e. a reverse step or a double-bit jump.
- prev<=state_in every cycle in every FSM state.
- Latency: all outputs are registered. step/home go high in the cycle after the edge that sampled the ADV and stay high for exactly one cycle.
- RUN state:
  - ADV: step=1; home=1 if the transition was 01->00, and cycle_cnt increments.
  - On cycle_cnt wrap from all-ones to 0: cycle_ovf<=1.
  - ILL: FSM->FAULT, err=1, err_from<=prev, err_to<=state_in; no step/home.
- FAULT state:
  - step and home are held 0; cycle_cnt is frozen.
  - Further ILL transitions do not overwrite err_from/err_to (first-error capture).
  - clr_err=1: FSM->RUN, err<=0. That cycle's transition is absorbed: no step, no count, no new error. err_from/err_to retain their values.
- clr_err in RUN: no effect, except that it also absorbs a coincident ILL (clr_err wins, no FAULT).
- hold_cnt, in both states:
  - HOLD: increment, saturating at 2^HOLD_W-1.
  - ADV or ILL: hold_cnt<=0.
  - stall is registered: stall<=(next hold_cnt >= HOLD_LIMIT).
- clr_cnt:
  - cycle_cnt<=0 and cycle_ovf<=0.
  - Wins over a coincident home increment (result 0, no ovf).
  - home is still pulsed.
- Reset asserted mid-operation: immediate clear of everything, including a pending step, regardless of FSM state.

Decomposition:
- Shared include gray_seq_defs.vh:
  - state encodings S00=2'b00, S10=2'b10, S11=2'b11, S01=2'b01;
  - FSM encodings RUN=1'b0, FAULT=1'b1;
  - a function gray_next(s) returning the legal successor.
- The upstream machine's testbench reuses gray_seq_defs.vh for expected-state checks.
- One natural sub-module: sat_counter (parameter W; ports Clk, rst, clr, inc, q), used for hold_cnt.
- The transition classifier, FSM and cycle counter stay in the top module.

Test Plan:
- Reset, then drive 00,10,11,01,00 on successive cycles -> step high on 4 consecutive cycles, home once (cycle after the 00 sample), cycle_cnt=1, err=0.
- Hold state_in=11 for 20 cycles with HOLD_LIMIT=16 -> hold_cnt reaches 16, stall rises on the 16th hold cycle; change to 01 -> hold_cnt=0, stall=0, step pulse.
- From 10 drive 00 (reverse), then 11 -> err=1, err_from=10, err_to=00 unchanged after 11; no step. Pulse clr_err -> err=0; next legal advance produces a step.
- ILL and clr_err on the same edge -> err stays 0, no step, hold_cnt=0.
- CNT_W=2: run 4 full revolutions -> cycle_cnt 1,2,3,0, cycle_ovf=1 after the 4th. clr_cnt coincident with the 5th home -> cycle_cnt=0, ovf=0, home pulsed.
- Pull rst low asynchronously mid-revolution and mid-FAULT -> all outputs 0 immediately; after release, first sample 10 -> step, no error.

Source files
------------

// File: rtl/gray_cycle_monitor_pkg.sv
// Shared definitions for the Gray-cycle monitor: state and FSM encodings,
// transition classes and the legal-successor function of the upstream machine.
package gray_cycle_monitor_pkg;

  // {A,B} encodings of the upstream T-flip-flop machine.
  typedef enum logic [1:0] {
    S00 = 2'b00,
    S10 = 2'b10,
    S11 = 2'b11,
    S01 = 2'b01
  } gray_state_e;

  // Monitor FSM encodings.
  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } mon_fsm_e;

  // Classification of one sampled transition.
  typedef enum logic [1:0] {
    TR_HOLD = 2'd0,
    TR_ADV  = 2'd1,
    TR_ILL  = 2'd2
  } trans_e;

  // Legal successor while x=0: 00->10->11->01->00.
  function automatic logic [1:0] gray_next(input logic [1:0] s);
    case (s)
      S00:     gray_next = S10;
      S10:     gray_next = S11;
      S11:     gray_next = S01;
      default: gray_next = S00;
    endcase
  endfunction

  // Hold if unchanged, advance if the legal successor, otherwise illegal.
  function automatic trans_e classify(input logic [1:0] prev, input logic [1:0] cur);
    if (cur == prev)                 classify = TR_HOLD;
    else if (cur == gray_next(prev)) classify = TR_ADV;
    else                             classify = TR_ILL;
  endfunction

endpackage

// File: rtl/gray_cycle_monitor_if.sv
// Bus between the upstream producer side (master) and the monitor (slave).
interface gray_cycle_monitor_if #(
  parameter int CNT_W  = 8,
  parameter int HOLD_W = 8
);
  logic [1:0]        state_in;
  logic              clr_err;
  logic              clr_cnt;
  logic              step;
  logic              home;
  logic [CNT_W-1:0]  cycle_cnt;
  logic              cycle_ovf;
  logic [HOLD_W-1:0] hold_cnt;
  logic              stall;
  logic              err;
  logic [1:0]        err_from;
  logic [1:0]        err_to;

  modport master (
    output state_in, clr_err, clr_cnt,
    input  step, home, cycle_cnt, cycle_ovf, hold_cnt, stall, err, err_from, err_to
  );

  modport slave (
    input  state_in, clr_err, clr_cnt,
    output step, home, cycle_cnt, cycle_ovf, hold_cnt, stall, err, err_from, err_to
  );
endinterface

// File: rtl/gray_cycle_monitor_sat.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count up to all-ones and stick there until cleared.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst)                 q <= '0;
    else if (clr)             q <= '0;
    else if (inc && q != '1)  q <= q + W'(1);
  end

endmodule

// File: rtl/gray_cycle_monitor.sv
// Checks every sampled transition of the upstream {A,B} machine against the
// legal Gray sequence; reports steps, revolutions, hold time and first error.
module gray_cycle_monitor
  import gray_cycle_monitor_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int HOLD_W     = 8,
  parameter int HOLD_LIMIT = 16
) (
  input logic                 Clk,
  input logic                 rst,
  gray_cycle_monitor_if.slave bus
);

  logic [1:0]        prev;
  trans_e            tr;
  mon_fsm_e          fsm_q, fsm_d;
  logic              step_d, home_d, capture;
  logic              step_q, home_q;
  logic [1:0]        from_q, to_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;
  logic [HOLD_W-1:0] hold_q, hold_next;
  logic              stall_q;

  // Classify the current sample against the previous one.
  always_comb tr = classify(prev, bus.state_in);

  // Previous sample follows state_in every cycle, whatever the FSM state;
  // 00 at reset matches the producer's reset state.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) prev <= S00;
    else      prev <= bus.state_in;
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) fsm_q <= RUN;
    else      fsm_q <= fsm_d;
  end

  // Next state and per-cycle decisions; clr_err absorbs the coincident transition.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    fsm_d   = fsm_q;
    step_d  = 1'b0;
    home_d  = 1'b0;
    capture = 1'b0;
    case (fsm_q)
      RUN: begin
        if (tr == TR_ADV) begin
          step_d = 1'b1;
          home_d = (prev == S01);
        end else if (tr == TR_ILL && !bus.clr_err) begin
          fsm_d   = FAULT;
          capture = 1'b1;
        end
      end
      FAULT: begin
        if (bus.clr_err) fsm_d = RUN;
      end
      default: fsm_d = RUN;
    endcase
  end

  // Registered step/home pulses.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      step_q <= 1'b0;
      home_q <= 1'b0;
    end else begin
      step_q <= step_d;
      home_q <= home_d;
    end
  end

  // Error location is captured only on the RUN->FAULT edge, so later
  // illegal transitions while in FAULT leave it untouched.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      from_q <= 2'b00;
      to_q   <= 2'b00;
    end else if (capture) begin
      from_q <= prev;
      to_q   <= bus.state_in;
    end
  end

  // Revolution counter; clr_cnt beats a coincident home increment.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (bus.clr_cnt) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (home_d) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (&cnt_q) ovf_q <= 1'b1;
    end
  end

  // Hold-duration counter runs in both FSM states.
  sat_counter #(.W(HOLD_W)) u_hold (
    .Clk (Clk),
    .rst (rst),
    .clr (tr != TR_HOLD),
    .inc (tr == TR_HOLD),
    .q   (hold_q)
  );

  // Value the hold counter takes at this edge, so stall lines up with it.
  always_comb begin
    hold_next = '0;
    if (tr == TR_HOLD) hold_next = (hold_q == '1) ? hold_q : hold_q + HOLD_W'(1);
  end

  // Registered stall flag.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) stall_q <= 1'b0;
    else      stall_q <= (hold_next >= HOLD_W'(HOLD_LIMIT));
  end

  assign bus.step      = step_q;
  assign bus.home      = home_q;
  assign bus.cycle_cnt = cnt_q;
  assign bus.cycle_ovf = ovf_q;
  assign bus.hold_cnt  = hold_q;
  assign bus.stall     = stall_q;
  assign bus.err       = (fsm_q == FAULT);
  assign bus.err_from  = from_q;
  assign bus.err_to    = to_q;

endmodule

// File: tb/tb_gray_cycle_monitor.sv
// Self-checking bench for gray_cycle_monitor: directed vector table, hand-written
// hold/wrap/reset sequences, then random stimulus against a ring-position model.
module tb_gray_cycle_monitor;

  localparam int CW = 2;
  localparam int HW = 8;
  localparam int HL = 16;

  logic Clk = 1'b0;
  logic rst = 1'b0;

  gray_cycle_monitor_if #(.CNT_W(CW), .HOLD_W(HW)) bus ();

  gray_cycle_monitor #(.CNT_W(CW), .HOLD_W(HW), .HOLD_LIMIT(HL)) dut (
    .Clk (Clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The legal sequence is a ring; a transition is an advance when the new
  // state sits one position further round the ring.
  int ring[4] = '{0, 2, 3, 1};
  int m_prev, m_cnt, m_hold, m_from, m_to;
  bit m_fault, m_ovf, m_step, m_home, m_stall;

  function automatic int ring_pos(input int s);
    for (int i = 0; i < 4; i++) if (ring[i] == s) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_cnt = 0; m_hold = 0; m_from = 0; m_to = 0;
    m_fault = 0; m_ovf = 0; m_step = 0; m_home = 0; m_stall = 0;
  endtask

  task automatic model_step(input int st, input bit ce, input bit cc);
    bit is_hold, is_adv;
    is_hold = (st == m_prev);
    is_adv  = (ring_pos(st) == (ring_pos(m_prev) + 1) % 4);
    m_step = 0;
    m_home = 0;
    if (!m_fault) begin
      if (is_adv) begin
        m_step = 1;
        m_home = (m_prev == 1);
      end else if (!is_hold && !ce) begin
        m_fault = 1; m_from = m_prev; m_to = st;
      end
    end else if (ce) begin
      m_fault = 0;
    end
    if (cc) begin
      m_cnt = 0; m_ovf = 0;
    end else if (m_home) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == (1 << CW)) begin m_cnt = 0; m_ovf = 1; end
    end
    m_hold  = is_hold ? ((m_hold < (1 << HW) - 1) ? m_hold + 1 : m_hold) : 0;
    m_stall = (m_hold >= HL);
    m_prev  = st;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".step"},     32'(bus.step),      32'(m_step));
    check({tag, ".home"},     32'(bus.home),      32'(m_home));
    check({tag, ".cycle_cnt"},32'(bus.cycle_cnt), 32'(m_cnt));
    check({tag, ".cycle_ovf"},32'(bus.cycle_ovf), 32'(m_ovf));
    check({tag, ".hold_cnt"}, 32'(bus.hold_cnt),  32'(m_hold));
    check({tag, ".stall"},    32'(bus.stall),     32'(m_stall));
    check({tag, ".err"},      32'(bus.err),       32'(m_fault));
    check({tag, ".err_from"}, 32'(bus.err_from),  32'(m_from));
    check({tag, ".err_to"},   32'(bus.err_to),    32'(m_to));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".step"},     32'(bus.step),      0);
    check({tag, ".home"},     32'(bus.home),      0);
    check({tag, ".cycle_cnt"},32'(bus.cycle_cnt), 0);
    check({tag, ".cycle_ovf"},32'(bus.cycle_ovf), 0);
    check({tag, ".hold_cnt"}, 32'(bus.hold_cnt),  0);
    check({tag, ".stall"},    32'(bus.stall),     0);
    check({tag, ".err"},      32'(bus.err),       0);
    check({tag, ".err_from"}, 32'(bus.err_from),  0);
    check({tag, ".err_to"},   32'(bus.err_to),    0);
  endtask

  // Drive on the falling edge, let the rising edge sample, look 1 ns later.
  task automatic cyc(input logic [1:0] st, input bit ce, input bit cc);
    @(negedge Clk);
    bus.state_in = st;
    bus.clr_err  = ce;
    bus.clr_cnt  = cc;
    model_step(int'(st), ce, cc);
    @(posedge Clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0] st;
    logic       ce, cc;
    logic       e_step, e_home, e_err;
    logic [1:0] e_from, e_to;
    int         e_cnt, e_hold;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [1:0] st;

    bus.state_in = 2'b00;
    bus.clr_err  = 1'b0;
    bus.clr_cnt  = 1'b0;
    model_reset();

    //          st     ce cc  stp hom err frm    to     cnt hold
    vecs = '{
      '{2'b00, 0, 0,  0,  0,  0, 2'b00, 2'b00, 0,  1},  // hold at reset state
      '{2'b10, 0, 0,  1,  0,  0, 2'b00, 2'b00, 0,  0},
      '{2'b11, 0, 0,  1,  0,  0, 2'b00, 2'b00, 0,  0},
      '{2'b01, 0, 0,  1,  0,  0, 2'b00, 2'b00, 0,  0},
      '{2'b00, 0, 0,  1,  1,  0, 2'b00, 2'b00, 1,  0},  // home, first revolution
      '{2'b10, 0, 0,  1,  0,  0, 2'b00, 2'b00, 1,  0},
      '{2'b00, 0, 0,  0,  0,  1, 2'b10, 2'b00, 1,  0},  // reverse step -> FAULT
      '{2'b11, 0, 0,  0,  0,  1, 2'b10, 2'b00, 1,  0},  // second error not captured
      '{2'b11, 1, 0,  0,  0,  0, 2'b10, 2'b00, 1,  1},  // clr_err, capture retained
      '{2'b01, 0, 0,  1,  0,  0, 2'b10, 2'b00, 1,  0},  // legal advance steps again
      '{2'b11, 1, 0,  0,  0,  0, 2'b10, 2'b00, 1,  0},  // ILL absorbed by clr_err
      '{2'b01, 0, 0,  1,  0,  0, 2'b10, 2'b00, 1,  0},
      '{2'b00, 0, 1,  1,  1,  0, 2'b10, 2'b00, 0,  0}   // clr_cnt beats home
    };

    // Reset state.
    repeat (2) @(posedge Clk);
    #1;
    check_all_zero("reset");
    #1 rst = 1'b1;

    foreach (vecs[i]) begin
      cyc(vecs[i].st, vecs[i].ce, vecs[i].cc);
      check($sformatf("vec%0d.step", i),      32'(bus.step),      32'(vecs[i].e_step));
      check($sformatf("vec%0d.home", i),      32'(bus.home),      32'(vecs[i].e_home));
      check($sformatf("vec%0d.err", i),       32'(bus.err),       32'(vecs[i].e_err));
      check($sformatf("vec%0d.err_from", i),  32'(bus.err_from),  32'(vecs[i].e_from));
      check($sformatf("vec%0d.err_to", i),    32'(bus.err_to),    32'(vecs[i].e_to));
      check($sformatf("vec%0d.cycle_cnt", i), 32'(bus.cycle_cnt), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d.hold_cnt", i),  32'(bus.hold_cnt),  32'(vecs[i].e_hold));
    end

    // Hold at 11 for 20 cycles: stall rises on the 16th hold cycle.
    cyc(2'b10, 0, 0);
    cyc(2'b11, 0, 0);
    check("hold.entry", 32'(bus.hold_cnt), 0);
    for (int i = 1; i <= 20; i++) begin
      cyc(2'b11, 0, 0);
      check($sformatf("hold%0d.cnt", i),   32'(bus.hold_cnt), 32'(i));
      check($sformatf("hold%0d.stall", i), 32'(bus.stall),    32'(i >= HL));
      check($sformatf("hold%0d.step", i),  32'(bus.step),     0);
    end
    cyc(2'b01, 0, 0);
    check("hold.exit.cnt",   32'(bus.hold_cnt), 0);
    check("hold.exit.stall", 32'(bus.stall),    0);
    check("hold.exit.step",  32'(bus.step),     1);

    // Four revolutions on a 2-bit counter: 1,2,3,0 then overflow.
    for (int rev = 1; rev <= 4; rev++) begin
      cyc(2'b00, 0, 0);
      check($sformatf("rev%0d.home", rev), 32'(bus.home),      1);
      check($sformatf("rev%0d.cnt", rev),  32'(bus.cycle_cnt), 32'(rev % 4));
      check($sformatf("rev%0d.ovf", rev),  32'(bus.cycle_ovf), 32'(rev == 4));
      cyc(2'b10, 0, 0);
      cyc(2'b11, 0, 0);
      cyc(2'b01, 0, 0);
    end
    cyc(2'b00, 0, 1);
    check("rev5.home", 32'(bus.home),      1);
    check("rev5.cnt",  32'(bus.cycle_cnt), 0);
    check("rev5.ovf",  32'(bus.cycle_ovf), 0);

    // Asynchronous reset mid-revolution while a step pulse is showing.
    cyc(2'b10, 0, 0);
    check("rstrev.pre.step", 32'(bus.step), 1);
    bus.state_in = 2'b00;
    #1 rst = 1'b0;
    #1 check_all_zero("rstrev");
    #1 rst = 1'b1;
    model_reset();
    cyc(2'b10, 0, 0);
    check("rstrev.post.step", 32'(bus.step), 1);
    check("rstrev.post.err",  32'(bus.err),  0);

    // Asynchronous reset while in FAULT.
    cyc(2'b00, 0, 0);
    cyc(2'b11, 0, 0);
    check("rstflt.pre.err", 32'(bus.err), 1);
    bus.state_in = 2'b00;
    #1 rst = 1'b0;
    #1 check_all_zero("rstflt");
    #1 rst = 1'b1;
    model_reset();
    cyc(2'b10, 0, 0);
    check("rstflt.post.step", 32'(bus.step), 1);
    check("rstflt.post.err",  32'(bus.err),  0);
    check_model("rstflt.post");

    // Random traffic, mostly legal advances with holds, jumps and clears mixed in.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60)      st = 2'(ring[(ring_pos(m_prev) + 1) % 4]);
      else if (r < 85) st = 2'(m_prev);
      else             st = 2'($urandom_range(0, 3));
      cyc(st, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
      check_model($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
